exp4_detector_jogada: RTL and testbench
=======================================

Name: exp4_detector_jogada

Overview:
- Input-conditioning stage directly upstream of the game datapath's `chaves` input.
- Synchronises the raw 4-bit board buttons to `clock` and debounces them.
- Delivers a registered, stable play code plus a one-cycle `jogada_feita` pulse for the control unit, which uses it to trigger compare/register steps.
- Gives exactly one event per physical press, so the control unit never sees bounce or a held button as repeated plays.

Parameters:
- N_BOTOES, 4, number of button lines; width of `botoes` and `jogada`.
- DEBOUNCE_CYCLES, 50000, consecutive identical synchronised samples required to accept a press or a release (1 ms at 50 MHz); legal range 2..2^20.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- botoes  input  N_BOTOES  raw, asynchronous, bouncing button lines; 1 = pressed.
- habilita  input  1  from control unit; 1 = a newly accepted press is delivered.
- jogada  output  N_BOTOES  last delivered play code; held until the next delivery.
- jogada_feita  output  1  one-cycle pulse, high in the cycle `jogada` first shows a new value.
- ocupado  output  1  high whenever the FSM is not in OCIOSO.
- db_multipla  output  1  high while `jogada` holds a code with more than one bit set.
- db_estado  output  4  state code, zero-extended, for a hexa7seg display.

Behaviour:
- Synchroniser:
  - Two flip-flop stages per line (s1, s2); only s2 is used downstream.
  - Both stages are cleared by reset.
- Counter:
  - Width ceil(log2(DEBOUNCE_CYCLES)).
  - Cleared on every state entry.
  - Saturates and never wraps.
- Candidate register `cand`:
  - Width N_BOTOES.
  - Holds the pattern currently being filtered.
- States and encodings: OCIOSO=0, FILTRANDO=1, PRESSIONADO=2, SOLTANDO=3.
  - OCIOSO:
    - s2==0: stay.
    - s2!=0: load `cand`=s2, go to FILTRANDO.
  - FILTRANDO:
    - s2==0: go to OCIOSO (glitch rejected, no output).
    - s2!=0 and s2!=cand: reload `cand`=s2 and restart the count; stay in FILTRANDO.
    - s2==cand and count<DEBOUNCE_CYCLES-1: increment.
    - s2==cand and count==DEBOUNCE_CYCLES-1: accept the press and go to PRESSIONADO.
  - Accept action:
    - If habilita=1 on the accepting edge: `jogada`<=cand and `jogada_feita`<=1.
    - If habilita=0: `jogada` is unchanged and `jogada_feita` stays 0; the press is consumed and is not delivered later.
  - PRESSIONADO:
    - Stay while s2!=0; pattern changes while held are ignored.
    - s2==0: go to SOLTANDO.
  - SOLTANDO:
    - s2!=0: go back to PRESSIONADO (bounce on release).
    - s2==0 for DEBOUNCE_CYCLES consecutive samples: go to OCIOSO.
- Latency:
  - A raw input is first sampled at edge e0 and held stable.
  - `jogada_feita` rises on edge e0+DEBOUNCE_CYCLES+2 (the (DEBOUNCE_CYCLES+3)th edge, counting e0).
  - `jogada_feita` is high for exactly one clock.
- Re-triggering:
  - A new press requires a full debounced release first.
  - `jogada_feita` never fires twice without an intervening OCIOSO.
- Simultaneous buttons: accepted as one combined code, with `db_multipla`=1; the datapath treats it as a wrong play.
- Reset values, including mid-operation reset:
  - Every output is 0.
  - State is OCIOSO; s1, s2, `cand` and the counter are 0.
  - A press in progress is discarded.
- `jogada_feita` and `ocupado` are registered outputs, free of glitches.

Decomposition:
- Shared package `exp4_pkg`:
  - The four state encodings.
  - Default DEBOUNCE_CYCLES.
  - N_BOTOES.
- Sub-module `sincronizador_2ff`:
  - Parameterised width, with asynchronous active-high reset.
  - Is the one natural sub-module, instantiated once for the `botoes` bus.
- Counter and FSM stay in this module.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean press: `botoes`=4'b0010 from edge 0, held for 20 cycles, then released.
  - `jogada_feita`=1 only in the cycle after edge 6.
  - `jogada`=4'b0010 from then on.
  - `db_estado` goes 0→1→2→3→0.
- Bounce: toggle `botoes` 0010/0000 every cycle for 6 cycles, then hold 0010.
  - No pulse during the bounce.
  - Exactly one pulse, 7 edges after the final stable edge.
- Held button plus release bounce: hold 0100 for 30 cycles, release with 0/0100/0 chatter over 3 cycles.
  - Exactly one pulse in total.
  - Returns to OCIOSO 4 samples after the last chatter.
- habilita=0 during acceptance of 1000:
  - No pulse and `jogada` unchanged.
  - A subsequent press of 0001 with habilita=1 gives a pulse with `jogada`=0001.
- Multi-press and reset: press 0011 stable.
  - `jogada`=0011 and `db_multipla`=1.
  - Assert reset mid-FILTRANDO on the next press: all outputs 0 at once, no pulse after reset is released.

Source files
------------

// File: rtl/exp4_detector_jogada_pkg.sv
// Shared definitions for the play detector: FSM state encodings and default sizes.
package exp4_pkg;

  // Default number of button lines on the board.
  localparam int N_BOTOES_DEF = 4;

  // Default filter length: 1 ms of stable samples at 50 MHz.
  localparam int DEBOUNCE_CYCLES_DEF = 50000;

  // Detector states; the numeric codes are shown on the hexa7seg debug display.
  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    FILTRANDO   = 2'd1,
    PRESSIONADO = 2'd2,
    SOLTANDO    = 2'd3
  } estado_t;

  // Zero-extends a state code to the 4-bit digit driven into the display decoder.
  function automatic logic [3:0] codigo_estado(input estado_t s);
    return {2'b00, s};
  endfunction

endpackage

// File: rtl/exp4_detector_jogada_if.sv
// Button-side and control-side signals of the play detector, bundled for port lists.
interface exp4_detector_jogada_if
  import exp4_pkg::*;
#(
  parameter int N = N_BOTOES_DEF
);

  logic [N-1:0] botoes;        // raw, bouncing button lines (1 = pressed)
  logic         habilita;      // control unit accepts a new play
  logic [N-1:0] jogada;        // last delivered play code
  logic         jogada_feita;  // one-cycle pulse when jogada changes
  logic         ocupado;       // detector is not idle
  logic         db_multipla;   // delivered code has more than one bit set
  logic [3:0]   db_estado;     // state code for the debug display

  // Drives buttons and enable, observes the detector results.
  modport master (
    output botoes, habilita,
    input  jogada, jogada_feita, ocupado, db_multipla, db_estado
  );

  // The detector itself.
  modport slave (
    input  botoes, habilita,
    output jogada, jogada_feita, ocupado, db_multipla, db_estado
  );

endinterface

// File: rtl/exp4_detector_jogada_sincronizador_2ff.sv
// Two-flop synchroniser for an asynchronous bus; each bit is synchronised independently.
module sincronizador_2ff #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  // Shift the raw lines through two flops to resolve metastability.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/exp4_detector_jogada.sv
// Button play detector: synchronises and debounces the board buttons and delivers
// one registered play code with a single-cycle pulse per physical press.
module exp4_detector_jogada
  import exp4_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  exp4_detector_jogada_if.slave  bus
);

  // Counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int           CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BOTOES-1:0] s2;
  logic                s2_ativo;
  logic                cand_igual;
  logic [CW-1:0]       count_d;

  estado_t             state_q;
  logic [CW-1:0]       count_q;
  logic [N_BOTOES-1:0] cand_q;
  logic [N_BOTOES-1:0] jogada_q;
  logic                feita_q;
  logic                ocupado_q;
  logic                multipla_q;

  sincronizador_2ff #(
    .W (N_BOTOES)
  ) u_sinc (
    .clock (clock),
    .reset (reset),
    .d_i   (bus.botoes),
    .q_o   (s2)
  );

  assign s2_ativo   = (s2 != '0);
  assign cand_igual = (s2 == cand_q);
  // Saturating increment: the counter holds at CMAX rather than wrapping.
  assign count_d    = (count_q == CMAX) ? count_q : count_q + 1'b1;

  // Debounce FSM with counter, candidate and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= OCIOSO;
      count_q    <= '0;
      cand_q     <= '0;
      jogada_q   <= '0;
      feita_q    <= 1'b0;
      ocupado_q  <= 1'b0;
      multipla_q <= 1'b0;
    end else begin
      feita_q <= 1'b0;
      case (state_q)
        OCIOSO: begin
          if (s2_ativo) begin
            cand_q    <= s2;
            count_q   <= '0;
            state_q   <= FILTRANDO;
            ocupado_q <= 1'b1;
          end
        end

        FILTRANDO: begin
          if (!s2_ativo) begin
            // Short glitch: drop it without touching the outputs.
            count_q   <= '0;
            state_q   <= OCIOSO;
            ocupado_q <= 1'b0;
          end else if (!cand_igual) begin
            // Pattern still settling (e.g. second finger landing): restart on it.
            cand_q  <= s2;
            count_q <= '0;
          end else if (count_q == CMAX) begin
            // Press accepted; it is consumed even if the control unit is not listening.
            count_q <= '0;
            state_q <= PRESSIONADO;
            if (bus.habilita) begin
              jogada_q   <= cand_q;
              feita_q    <= 1'b1;
              multipla_q <= ($countones(cand_q) > 1);
            end
          end else begin
            count_q <= count_d;
          end
        end

        PRESSIONADO: begin
          // Changes of pattern while held are ignored; only a release matters.
          if (!s2_ativo) begin
            count_q <= '0;
            state_q <= SOLTANDO;
          end
        end

        SOLTANDO: begin
          if (s2_ativo) begin
            // Release bounce: still held.
            count_q <= '0;
            state_q <= PRESSIONADO;
          end else if (count_q == CMAX) begin
            count_q   <= '0;
            state_q   <= OCIOSO;
            ocupado_q <= 1'b0;
          end else begin
            count_q <= count_d;
          end
        end

        default: begin
          count_q   <= '0;
          state_q   <= OCIOSO;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.jogada       = jogada_q;
  assign bus.jogada_feita = feita_q;
  assign bus.ocupado      = ocupado_q;
  assign bus.db_multipla  = multipla_q;
  assign bus.db_estado    = codigo_estado(state_q);

endmodule

// File: tb/tb_exp4_detector_jogada.sv
// Directed bench for the play detector with a short filter length (4 samples).
module tb_exp4_detector_jogada;

  localparam int N = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  int   exp_est;

  exp4_detector_jogada_if #(.N(N)) bus ();

  exp4_detector_jogada #(
    .N_BOTOES        (N),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later; counts delivered pulses.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.jogada_feita === 1'b1) pulses++;
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    bus.botoes   = '0;
    bus.habilita = 1'b1;
    rst          = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    check("rst_jogada",   bus.jogada,       0);
    check("rst_feita",    bus.jogada_feita, 0);
    check("rst_ocupado",  bus.ocupado,      0);
    check("rst_multipla", bus.db_multipla,  0);
    check("rst_estado",   bus.db_estado,    0);
    wait_cycles(2);
    pulses = 0;

    // Clean press of 0010: raw seen at edge 0, pulse after edge 6.
    bus.botoes = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      step();
      exp_est = (i < 2) ? 0 : (i < 6) ? 1 : 2;
      check("t1_feita",   bus.jogada_feita, (i == 6) ? 1 : 0);
      check("t1_estado",  bus.db_estado,    exp_est);
      check("t1_ocupado", bus.ocupado,      (exp_est != 0) ? 1 : 0);
      if (i >= 6) check("t1_jogada", bus.jogada, 4'b0010);
    end
    bus.botoes = 4'b0000;
    for (int j = 0; j < 10; j++) begin
      step();
      exp_est = (j < 2) ? 2 : (j < 6) ? 3 : 0;
      check("t1_rel_estado",  bus.db_estado, exp_est);
      check("t1_rel_ocupado", bus.ocupado,   (exp_est != 0) ? 1 : 0);
    end
    check("t1_pulses",   pulses,          1);
    check("t1_multipla", bus.db_multipla, 0);
    $display("clean press 0010: jogada=%b pulses=%0d", bus.jogada, pulses);

    // Bounce: alternate for 6 edges, then hold from edge 6; pulse after edge 12.
    pulses = 0;
    for (int i = 0; i < 17; i++) begin
      bus.botoes = (i < 6 && (i % 2) == 1) ? 4'b0000 : 4'b0010;
      step();
      check("t2_feita", bus.jogada_feita, (i == 12) ? 1 : 0);
    end
    check("t2_pulses", pulses, 1);
    bus.botoes = 4'b0000;
    wait_cycles(10);
    check("t2_estado_idle", bus.db_estado, 0);
    $display("bounce press 0010: pulses=%0d", pulses);

    // Held 0100 for 30 edges, then release chatter 0 / 0100 / 0.
    pulses = 0;
    for (int i = 0; i < 46; i++) begin
      bus.botoes = (i < 30 || i == 31) ? 4'b0100 : 4'b0000;
      step();
      if (i >= 30 && i <= 40) begin
        exp_est = (i <= 31) ? 2 : (i == 32) ? 3 : (i == 33) ? 2 : (i <= 37) ? 3 : 0;
        check("t3_estado", bus.db_estado, exp_est);
      end
      if (i == 6) check("t3_feita", bus.jogada_feita, 1);
    end
    check("t3_pulses", pulses,     1);
    check("t3_jogada", bus.jogada, 4'b0100);
    $display("held press 0100 with release chatter: pulses=%0d", pulses);

    // habilita=0 during acceptance of 1000: press consumed, not delivered.
    pulses       = 0;
    bus.habilita = 1'b0;
    bus.botoes   = 4'b1000;
    wait_cycles(12);
    check("t4_pulses_dis", pulses,        0);
    check("t4_jogada_dis", bus.jogada,    4'b0100);
    check("t4_estado_dis", bus.db_estado, 2);
    bus.habilita = 1'b1;
    wait_cycles(5);
    check("t4_pulses_late", pulses,     0);
    check("t4_jogada_late", bus.jogada, 4'b0100);
    bus.botoes = 4'b0000;
    wait_cycles(10);
    check("t4_estado_idle", bus.db_estado, 0);
    bus.botoes = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      step();
      check("t4_feita", bus.jogada_feita, (i == 6) ? 1 : 0);
    end
    check("t4_jogada",   bus.jogada,      4'b0001);
    check("t4_multipla", bus.db_multipla, 0);
    check("t4_pulses",   pulses,          1);
    bus.botoes = 4'b0000;
    wait_cycles(10);
    $display("disabled 1000 then enabled 0001: jogada=%b pulses=%0d", bus.jogada, pulses);

    // Multi-press 0011, then reset in the middle of filtering the next press.
    pulses     = 0;
    bus.botoes = 4'b0011;
    wait_cycles(12);
    check("t5_jogada",   bus.jogada,      4'b0011);
    check("t5_multipla", bus.db_multipla, 1);
    check("t5_pulses",   pulses,          1);
    bus.botoes = 4'b0000;
    wait_cycles(10);
    check("t5_estado_idle", bus.db_estado, 0);
    pulses     = 0;
    bus.botoes = 4'b1000;
    wait_cycles(4);
    check("t5_estado_filt",  bus.db_estado, 1);
    check("t5_ocupado_filt", bus.ocupado,   1);
    #2;
    rst        = 1'b1;
    bus.botoes = 4'b0000;
    #1;
    check("t5_rst_jogada",   bus.jogada,       0);
    check("t5_rst_feita",    bus.jogada_feita, 0);
    check("t5_rst_ocupado",  bus.ocupado,      0);
    check("t5_rst_multipla", bus.db_multipla,  0);
    check("t5_rst_estado",   bus.db_estado,    0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(15);
    check("t5_post_pulses", pulses,        0);
    check("t5_post_jogada", bus.jogada,    0);
    check("t5_post_estado", bus.db_estado, 0);
    $display("multi-press 0011 and mid-filter reset: pulses after reset=%0d", pulses);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
